// File: rtl/display_sched_pkg.sv
// Shared constants for the display frame scheduler: FSM state encoding,
// object slot indices and default register geometry.
package display_sched_pkg;

    // Default geometry of the display object register bank
    localparam int DEF_NUM_OBJ = 6;
    localparam int DEF_DATA_W  = 32;

    // Scheduler FSM state encoding (OPEN, ARMED, COPY)
    localparam logic [1:0] ST_OPEN  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_COPY  = 2'd2;

    // Object slot indices
    localparam int OBJ_PIPE1 = 0;
    localparam int OBJ_PIPE2 = 1;
    localparam int OBJ_PIPE3 = 2;
    localparam int OBJ_PIPE4 = 3;
    localparam int OBJ_BIRD  = 4;
    localparam int OBJ_SCORE = 5;

endpackage

// File: rtl/frame_tick_divider.sv
// Frame-boundary driven counters: a free-running 16-bit frame counter and a
// TICK_FRAMES divider that emits a one-cycle game_tick when it wraps.
module frame_tick_divider #(
    parameter int TICK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screen_end,
    output logic        game_tick,
    output logic [15:0] frame_count
);
    import display_sched_pkg::*;

    localparam logic [7:0] DIV_LAST = 8'(TICK_FRAMES - 1);

    logic [7:0]  div_q, div_d;
    logic        tick_q, tick_d;
    logic [15:0] cnt_q, cnt_d;

    // Advance counters on each frame boundary; tick is a registered pulse
    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        cnt_d  = cnt_q;
        if (screen_end) begin
            cnt_d = cnt_q + 16'd1;
            if (div_q == DIV_LAST) begin
                div_d  = 8'd0;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= 8'd0;
            tick_q <= 1'b0;
            cnt_q  <= 16'd0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            cnt_q  <= cnt_d;
        end
    end

    assign game_tick   = tick_q;
    assign frame_count = cnt_q;

endmodule

// File: rtl/display_frame_scheduler.sv
// Tear-free commit scheduler: object values are staged at any time and a
// committed batch is copied to the display registers only at a frame end.
// Optional build macro FRAME_MISS_STATS_EN adds a saturating counter of
// frames shown while staged data was still uncommitted.
//
// Handshake: a staging write takes effect on any cycle where wr_valid and
// wr_ready are both high; wr_ready is high only in OPEN. Writes to an index
// >= NUM_OBJ are accepted and dropped.
module display_frame_scheduler
    import display_sched_pkg::*;
#(
    parameter int NUM_OBJ     = DEF_NUM_OBJ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IDX_W       = 3,
    parameter int TICK_FRAMES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      screen_end,
    input  logic                      wr_valid,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ready,
    input  logic                      commit_req,
    output logic                      commit_done,
    output logic                      busy,
    output logic [NUM_OBJ*DATA_W-1:0] obj_flat,
    output logic                      game_tick,
    output logic [15:0]               frame_count,
    output logic [7:0]                missed_frames
);

    localparam int FLAT_W = NUM_OBJ * DATA_W;

    logic [1:0]        state_q, state_d;
    logic [FLAT_W-1:0] stage_q, stage_d;
    logic [FLAT_W-1:0] disp_q, disp_d;
    logic              dirty_q, dirty_d;
    logic              done_q, done_d;

    // FSM next state, staging writes and the frame-end copy
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        disp_d  = disp_q;
        dirty_d = dirty_q;
        done_d  = 1'b0;
        case (state_q)
            ST_OPEN: begin
                if (wr_valid) begin
                    for (int i = 0; i < NUM_OBJ; i++) begin
                        if (wr_idx == IDX_W'(i)) begin
                            stage_d[i*DATA_W +: DATA_W] = wr_data;
                            dirty_d = 1'b1;
                        end
                    end
                end
                // A write in the same cycle as the request joins the batch
                if (commit_req) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (screen_end) state_d = ST_COPY;
            end
            ST_COPY: begin
                disp_d  = stage_q;
                dirty_d = 1'b0;
                done_d  = 1'b1;
                state_d = ST_OPEN;
            end
            default: state_d = ST_OPEN;
        endcase
    end

    // State and register bank; reset aborts any pending commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OPEN;
            stage_q <= '0;
            disp_q  <= '0;
            dirty_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            disp_q  <= disp_d;
            dirty_q <= dirty_d;
            done_q  <= done_d;
        end
    end

    assign wr_ready    = (state_q == ST_OPEN);
    assign busy        = (state_q == ST_ARMED) || (state_q == ST_COPY);
    assign obj_flat    = disp_q;
    assign commit_done = done_q;

`ifdef FRAME_MISS_STATS_EN
    logic [7:0] miss_q, miss_d;

    // Count frames displayed while staged data sits uncommitted
    always_comb begin
        miss_d = miss_q;
        if (screen_end && (state_q == ST_OPEN) && dirty_q && (miss_q != 8'hFF))
            miss_d = miss_q + 8'd1;
    end

    // Stale-frame counter register
    always_ff @(posedge clk) begin
        if (reset) miss_q <= 8'd0;
        else       miss_q <= miss_d;
    end

    assign missed_frames = miss_q;
`else
    assign missed_frames = 8'd0;
`endif

    frame_tick_divider #(
        .TICK_FRAMES(TICK_FRAMES)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .screen_end (screen_end),
        .game_tick  (game_tick),
        .frame_count(frame_count)
    );

endmodule

// File: tb/tb_display_frame_scheduler.sv
// Directed bench for display_frame_scheduler with a commit scoreboard.
module tb_display_frame_scheduler;
    import display_sched_pkg::*;

    localparam int NUM_OBJ = 6;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = 3;
    localparam int FLAT_W  = NUM_OBJ * DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              screen_end = 1'b0;
    logic              wr_valid = 1'b0;
    logic [IDX_W-1:0]  wr_idx = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              commit_req = 1'b0;
    logic              commit_done;
    logic              busy;
    logic [FLAT_W-1:0] obj_flat;
    logic              game_tick;
    logic [15:0]       frame_count;
    logic [7:0]        missed_frames;

    display_frame_scheduler #(
        .NUM_OBJ(NUM_OBJ), .DATA_W(DATA_W), .IDX_W(IDX_W), .TICK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .screen_end(screen_end),
        .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ready(wr_ready),
        .commit_req(commit_req), .commit_done(commit_done), .busy(busy),
        .obj_flat(obj_flat), .game_tick(game_tick), .frame_count(frame_count),
        .missed_frames(missed_frames)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int tick_cnt = 0;
    int exp_frames = 0;
    int exp_ticks  = 0;
    int exp_div    = 0;
    logic [DATA_W-1:0] exp_obj [NUM_OBJ];
    logic [FLAT_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [FLAT_W-1:0] act, input logic [FLAT_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [FLAT_W-1:0] pack_model();
        logic [FLAT_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_OBJ; i++) f[i*DATA_W +: DATA_W] = exp_obj[i];
        return f;
    endfunction

    // scoreboard monitor: each commit_done must match the next expected batch
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && game_tick) tick_cnt++;
            if (!reset && commit_done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_commit_done", 1, 0);
                end else begin
                    check("commit_obj_flat", obj_flat, exp_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_obj(input int idx, input logic [DATA_W-1:0] data, input bit accepted);
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_idx = IDX_W'(idx); wr_data = data;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        if (accepted && idx < NUM_OBJ) exp_obj[idx] = data;
    endtask

    task automatic req_commit();
        @(posedge clk); #1;
        commit_req = 1'b1;
        @(posedge clk); #1;
        commit_req = 1'b0;
    endtask

    // one-cycle frame boundary; leaves control #1 after the edge that sampled it
    task automatic pulse_se();
        @(posedge clk); #1;
        screen_end = 1'b1;
        @(posedge clk); #1;
        screen_end = 1'b0;
        exp_frames++;
        if (exp_div == 1) begin exp_div = 0; exp_ticks++; end
        else exp_div++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_OBJ; i++) exp_obj[i] = '0;
        exp_frames = 0; exp_ticks = 0; exp_div = 0;
    endtask

    int done_before;
    int tick_before;
    logic [FLAT_W-1:0] before_flat;

    initial begin
        model_reset();
        // reset
        cycles(3);
        reset = 1'b0;
        @(negedge clk);
        check("reset_obj_flat", obj_flat, '0);
        check("reset_frame_count", FLAT_W'(frame_count), '0);
        check("reset_commit_done", FLAT_W'(commit_done), '0);
        check("reset_game_tick", FLAT_W'(game_tick), '0);
        check("reset_busy", FLAT_W'(busy), '0);
        check("reset_wr_ready", FLAT_W'(wr_ready), 1);
        check("reset_missed", FLAT_W'(missed_frames), '0);

        // idle three frames
        tick_before = tick_cnt;
        for (int f = 0; f < 3; f++) begin pulse_se(); cycles(2); end
        @(negedge clk);
        check("idle_frame_count", FLAT_W'(frame_count), 3);
        check("idle_ticks", FLAT_W'(tick_cnt - tick_before), 1);
        check("idle_no_commit", FLAT_W'(done_cnt), 0);
        check("idle_obj_flat", obj_flat, '0);

        // basic commit with latency checks
        write_obj(OBJ_PIPE2, 32'h00A0_0120, 1);
        write_obj(OBJ_BIRD,  32'h0000_00C8, 1);
        req_commit();
        @(negedge clk);
        check("armed_busy", FLAT_W'(busy), 1);
        check("armed_wr_ready", FLAT_W'(wr_ready), 0);
        exp_q.push_back(pack_model());
        pulse_se();
        @(negedge clk);
        check("t1_obj_flat_unchanged", obj_flat, '0);
        check("t1_commit_done_low", FLAT_W'(commit_done), 0);
        @(negedge clk);
        check("t2_pipe2", FLAT_W'(obj_flat[OBJ_PIPE2*DATA_W +: DATA_W]), FLAT_W'(32'h00A0_0120));
        check("t2_bird", FLAT_W'(obj_flat[OBJ_BIRD*DATA_W +: DATA_W]), FLAT_W'(32'h0000_00C8));
        check("t2_commit_done", FLAT_W'(commit_done), 1);
        @(negedge clk);
        check("t3_commit_done_low", FLAT_W'(commit_done), 0);
        check("t3_open", FLAT_W'(busy), 0);

        // writes and repeated requests while ARMED are ignored
        done_before = done_cnt;
        req_commit();
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_idx = 3'd0; wr_data = 32'h55;
        @(negedge clk);
        check("armed_write_not_ready", FLAT_W'(wr_ready), 0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        req_commit();
        exp_q.push_back(pack_model());
        pulse_se();
        cycles(4);
        req_commit();
        cycles(3);
        @(negedge clk);
        check("armed_req_still_armed", FLAT_W'(busy), 1);
        pulse_se();
        exp_q.push_back(pack_model());
        cycles(4);
        @(negedge clk);
        check("armed_pipe1_absent", FLAT_W'(obj_flat[OBJ_PIPE1*DATA_W +: DATA_W]), '0);
        check("armed_commit_count", FLAT_W'(done_cnt - done_before), 2);

        // out-of-range index: accepted, no change, dirty stays clear
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_idx = 3'd7; wr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("oor_wr_ready", FLAT_W'(wr_ready), 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        pulse_se(); cycles(1);
        pulse_se(); cycles(1);
        @(negedge clk);
        check("oor_missed", FLAT_W'(missed_frames), 0);
        before_flat = obj_flat;
        check("oor_obj_flat", before_flat, pack_model());
        req_commit();
        exp_q.push_back(pack_model());
        pulse_se();
        cycles(3);

        // dirty for 300 frames without a commit
        write_obj(OBJ_SCORE, 32'd9, 1);
        for (int f = 0; f < 300; f++) pulse_se();
        cycles(2);
        @(negedge clk);
`ifdef FRAME_MISS_STATS_EN
        check("missed_saturated", FLAT_W'(missed_frames), 255);
`else
        check("missed_disabled", FLAT_W'(missed_frames), 0);
`endif
        check("frame_count_total", FLAT_W'(frame_count), FLAT_W'(exp_frames));
        check("tick_total", FLAT_W'(tick_cnt), FLAT_W'(exp_ticks));

        // reset the cycle after screen_end in ARMED aborts the commit
        done_before = done_cnt;
        req_commit();
        pulse_se();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        model_reset();
        cycles(3);
        @(negedge clk);
        check("abort_no_commit_done", FLAT_W'(done_cnt - done_before), 0);
        check("abort_obj_flat", obj_flat, '0);
        check("abort_open", FLAT_W'(busy), 0);
        check("abort_frame_count", FLAT_W'(frame_count), 0);
        check("abort_missed", FLAT_W'(missed_frames), 0);
        check("scoreboard_drained", FLAT_W'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_frame_scheduler.md
Name: display_frame_scheduler

Overview:
- Tear-free update scheduler between the processor-side game registers and the VGA display path. Pipe, bird and score values are written into staging registers at any time. A batch is committed to the display-facing registers only at a frame boundary (screen_end), so every frame shows one coherent game state.
- Also derives the game-logic tick and a frame counter from frame boundaries.
- Sits between the register-file/IO controller and the VGA controller object inputs.

Parameters:
- NUM_OBJ, 6, number of display objects (idx 0-3 pipe1..pipe4, 4 bird_top_left, 5 current_score)
- DATA_W, 32, width of each object register
- IDX_W, 3, width of the write index
- TICK_FRAMES, 2, frames per game_tick pulse (legal 1..255)

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  synchronous, active-high reset
- screen_end  in  1  single-cycle pulse in the clk domain, once per frame (synchronised upstream)
- wr_valid  in  1  staging write request
- wr_idx  in  IDX_W  object index
- wr_data  in  DATA_W  value to stage
- wr_ready  out  1  staging write accepted this cycle when high with wr_valid
- commit_req  in  1  single-cycle pulse: staged batch complete, publish at next frame end
- commit_done  out  1  single-cycle pulse: new values visible on obj_flat
- busy  out  1  high in ARMED or COPY
- obj_flat  out  NUM_OBJ*DATA_W  display registers; object i at bits [i*DATA_W +: DATA_W]
- game_tick  out  1  single-cycle pulse every TICK_FRAMES frames
- frame_count  out  16  free-running frame counter
- missed_frames  out  8  stale-frame counter (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high):
  - State is OPEN.
  - All staging and display registers are 0, so the VGA shows the splash screen.
  - commit_done = 0, game_tick = 0, frame_count = 0, tick divider = 0, dirty = 0, missed_frames = 0.
  - Reset asserted mid-COPY or mid-ARMED aborts the commit; no commit_done is issued.
- States:
  - OPEN: wr_ready = 1. A write occurs when wr_valid & wr_ready and sets dirty.
    - wr_idx >= NUM_OBJ: the write is accepted and discarded; dirty is unchanged.
    - commit_req -> ARMED. A write in the same cycle as commit_req is accepted and included in the batch.
    - screen_end in OPEN copies nothing.
  - ARMED: wr_ready = 0; commit_req is ignored. screen_end -> COPY.
  - COPY: one cycle. Display registers <= staging (all NUM_OBJ entries), dirty <= 0, commit_done <= 1 (registered, high the following cycle), then -> OPEN. commit_req and writes are ignored.
- Latency:
  - screen_end in ARMED at cycle T -> obj_flat updated at T+2, commit_done high at T+2.
  - commit_req and screen_end in the same cycle while OPEN: the request arms only, and the commit happens at the next frame end.
- Staging persists after a commit. Unwritten objects keep their previously staged values.
- Frame counters on each screen_end:
  - frame_count increments and wraps 0xFFFF -> 0x0000.
  - The divider counts 0..TICK_FRAMES-1. game_tick is a registered pulse one cycle after the screen_end on which the divider wraps. With TICK_FRAMES=1, game_tick pulses every frame.
- All outputs are registered except wr_ready and busy, which are decoded from state.

Optional Feature:
- Macro FRAME_MISS_STATS_EN.
- Defined: missed_frames increments (saturating at 255) on each screen_end while in OPEN with dirty=1, i.e. a frame shown with staged but uncommitted data. It is cleared only by reset.
- Undefined: missed_frames is tied to 0 and the counter logic is absent.

Decomposition:
- Package display_sched_pkg holds:
  - The state enum (OPEN, ARMED, COPY).
  - Object index constants OBJ_PIPE1..OBJ_PIPE4, OBJ_BIRD, OBJ_SCORE.
  - Default DATA_W/NUM_OBJ.
- One sub-module: frame_tick_divider. It implements the screen_end-driven TICK_FRAMES divider plus frame_count, and outputs game_tick and frame_count.

Test Plan:
- Reset, then idle for 3 frames: obj_flat = 0, commit_done never pulses, frame_count = 3, game_tick pulses once (TICK_FRAMES=2).
- Write idx1=0x00A0_0120 and idx4=0x0000_00C8, commit_req, screen_end at T: obj_flat unchanged before T+2; at T+2, pipe2 = 0x00A00120, bird = 0xC8, commit_done 1 cycle high, then back to OPEN.
- In ARMED, drive wr_valid idx0=0x55: wr_ready = 0, value absent from both staging and display after commit; commit_req repeated in ARMED is ignored, giving exactly one commit_done.
- Write idx7=0xFFFF_FFFF: accepted, no register changes, dirty stays 0; with FRAME_MISS_STATS_EN, 2 frames pass and missed_frames stays 0.
- Write idx5=9, no commit, 300 screen_ends with FRAME_MISS_STATS_EN: missed_frames = 255 (saturated); without the macro it is 0.
- Assert reset the cycle after screen_end in ARMED: no commit_done, obj_flat = 0, state OPEN, frame_count = 0.
